// File: rtl/controller_sequencer.sv
// Controller/sequencer for a SAP-1 style machine: a six-state one-hot ring
// counter (T1..T6) plus a combinational decode of T and OPCODE into the
// 12-bit control word. A halt opcode seen in T4 freezes the ring until CLR.
module controller_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  OPCODE,
    output logic [5:0]  T,
    output logic [11:0] CON,
    output logic        HLT
);

    // One-hot ring positions; any other value is illegal and recovers to T1.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    // Control word bit order: {CP, EP, LM_N, CE_N, LI_N, EI_N, LA_N, EA, SU, EU, LB_N, LO_N}
    localparam logic [11:0] CON_NOP     = 12'h3E3;
    localparam logic [11:0] CON_FETCH1  = 12'h5E3;
    localparam logic [11:0] CON_FETCH2  = 12'hBE3;
    localparam logic [11:0] CON_FETCH3  = 12'h263;
    localparam logic [11:0] CON_ADDR    = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5  = 12'h2C3;
    localparam logic [11:0] CON_LDB_T5  = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6  = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6  = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4  = 12'h3F2;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    tstate_e state;
    tstate_e state_next;
    logic    halt_q;
    logic    halt_now;

    // Halt request is only honoured in T4; fetch states ignore OPCODE.
    assign halt_now = (state == T4) && (OPCODE == OP_HLT);

    // State register: ring position and sticky halt flag, async clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= T1;
            halt_q <= 1'b0;
        end else begin
            state  <= state_next;
            halt_q <= halt_q | halt_now;
        end
    end

    // Next-state: advance the ring, freeze at T4 when halting, recover from non-one-hot.
    always_comb begin
        state_next = T1;
        if (halt_q || halt_now) begin
            state_next = T4;
        end else begin
            case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                T3:      state_next = T4;
                T4:      state_next = T5;
                T5:      state_next = T6;
                T6:      state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    // Output decode: control word from ring position and opcode, no latency.
    always_comb begin
        T   = state;
        HLT = halt_q | halt_now;
        CON = CON_NOP;
        if (!halt_q) begin
            case (state)
                T1: CON = CON_FETCH1;
                T2: CON = CON_FETCH2;
                T3: CON = CON_FETCH3;
                T4: begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB: CON = CON_ADDR;
                        OP_OUT:                 CON = CON_OUT_T4;
                        default:                CON = CON_NOP;
                    endcase
                end
                T5: begin
                    case (OPCODE)
                        OP_LDA:         CON = CON_LDA_T5;
                        OP_ADD, OP_SUB: CON = CON_LDB_T5;
                        default:        CON = CON_NOP;
                    endcase
                end
                T6: begin
                    case (OPCODE)
                        OP_ADD:  CON = CON_ADD_T6;
                        OP_SUB:  CON = CON_SUB_T6;
                        default: CON = CON_NOP;
                    endcase
                end
                default: CON = CON_NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: expected {T, CON, HLT} are
// queued as each cycle is driven and compared on the following falling edge.
module tb_controller_sequencer;

    logic        CLK;
    logic        CLR;
    logic [3:0]  OPCODE;
    logic [5:0]  T;
    logic [11:0] CON;
    logic        HLT;

    typedef struct packed {
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_cmp;
    int unsigned n_err;

    controller_sequencer dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .OPCODE (OPCODE),
        .T      (T),
        .CON    (CON),
        .HLT    (HLT)
    );

    // 10-unit clock period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Bus drivers active in a control word: CP, EP, CE_N low, EI_N low, EA, EU
    function automatic int unsigned drivers(input logic [11:0] c);
        return int'(c[11]) + int'(c[10]) + int'(!c[8]) + int'(!c[6]) + int'(c[4]) + int'(c[2]);
    endfunction

    // Scoreboard and invariant monitor, sampled away from the rising edge
    always @(negedge CLK) begin
        exp_t e;
        check("t_onehot", {31'd0, $onehot(T)}, 32'd1);
        check("bus_drivers_le1", {31'd0, (drivers(CON) <= 1)}, 32'd1);
        assert ($onehot(T) && drivers(CON) <= 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("T",   {26'd0, T},   {26'd0, e.t});
            check("CON", {20'd0, CON}, {20'd0, e.con});
            check("HLT", {31'd0, HLT}, {31'd0, e.hlt});
        end
    end

    // Drive one cycle's opcode and queue what the DUT should show during it
    task automatic cyc(input logic [3:0] op, input logic [5:0] et, input logic [11:0] ec, input logic eh);
        exp_t e;
        OPCODE = op;
        e.t = et;
        e.con = ec;
        e.hlt = eh;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Whole instruction: fetch with fetch_op on OPCODE, execute with op
    task automatic instr(input logic [3:0] fetch_op, input logic [3:0] op,
                         input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
        cyc(fetch_op, 6'b000001, 12'h5E3, 1'b0);
        cyc(fetch_op, 6'b000010, 12'hBE3, 1'b0);
        cyc(fetch_op, 6'b000100, 12'h263, 1'b0);
        cyc(op,       6'b001000, c4,      1'b0);
        cyc(op,       6'b010000, c5,      1'b0);
        cyc(op,       6'b100000, c6,      1'b0);
    endtask

    // Assert CLR between edges and confirm the reset values appear at once
    task automatic async_clear(input string tag);
        #2;
        CLR = 1'b1;
        #1;
        check({tag, "_T"},   {26'd0, T},   32'h01);
        check({tag, "_CON"}, {20'd0, CON}, 32'h5E3);
        check({tag, "_HLT"}, {31'd0, HLT}, 32'd0);
        @(posedge CLK);
        #1;
        cyc(4'h0, 6'b000001, 12'h5E3, 1'b0);
        CLR = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        CLR    = 1'b1;
        OPCODE = 4'h0;
        @(posedge CLK);
        #1;
        // Held in reset across edges
        cyc(4'h0, 6'b000001, 12'h5E3, 1'b0);
        cyc(4'hF, 6'b000001, 12'h5E3, 1'b0);
        CLR = 1'b0;

        // LDA, then ADD and SUB back-to-back
        instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
        instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
        instr(4'h2, 4'h2, 12'h1A3, 12'h2E1, 12'h3CF);

        // OUT with halt opcode on the bus during fetch, then undefined 0101
        instr(4'hF, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
        instr(4'h5, 4'h5, 12'h3E3, 12'h3E3, 12'h3E3);

        // Remaining undefined opcodes decode as NOP and never halt
        for (int unsigned op = 3; op <= 13; op++)
            instr(4'(op), 4'(op), 12'h3E3, 12'h3E3, 12'h3E3);

        // Halt: fetch with 1111 does nothing; T4 with 1111 halts
        cyc(4'hF, 6'b000001, 12'h5E3, 1'b0);
        cyc(4'hF, 6'b000010, 12'hBE3, 1'b0);
        cyc(4'hF, 6'b000100, 12'h263, 1'b0);
        cyc(4'hF, 6'b001000, 12'h3E3, 1'b1);
        for (int unsigned i = 0; i < 12; i++)
            cyc(4'(i), 6'b001000, 12'h3E3, 1'b1);

        // Only CLR leaves the halted state
        async_clear("clr_halted");
        instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3);

        // CLR during T5 of ADD
        cyc(4'h1, 6'b000001, 12'h5E3, 1'b0);
        cyc(4'h1, 6'b000010, 12'hBE3, 1'b0);
        cyc(4'h1, 6'b000100, 12'h263, 1'b0);
        cyc(4'h1, 6'b001000, 12'h1A3, 1'b0);
        async_clear("clr_mid_t5");
        instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7);

        // Let the monitor drain the last expectation
        @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #20000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: CLK clocks all state on its rising edge; CLR, when high, resets all state immediately, independent of CLK.
REQ-002 Port list (name  direction  width  meaning):
- CLK     input   1   system clock; the only clock
- CLR     input   1   asynchronous active-high reset
- OPCODE  input   4   upper nibble of the instruction register; held stable by the datapath from T4 onward
- T       output  6   one-hot T-state; bit0 = T1 ... bit5 = T6
- CON     output  12  control word, bit11..bit0 = {CP, EP, LM_N, CE_N, LI_N, EI_N, LA_N, EA, SU, EU, LB_N, LO_N}
- HLT     output  1   high while the machine is halted
REQ-003 Signals suffixed _N in CON SHALL be active-low; all other CON bits SHALL be active-high.

Function
REQ-004 T SHALL be a 6-state ring counter that is always one-hot: T1->T2->T3->T4->T5->T6->T1, advancing one position per rising CLK edge.
REQ-005 CON SHALL be a combinational decode of T and OPCODE, with no cycle of latency; idle value (NOP) = 0x3E3.
REQ-006 Fetch states SHALL decode independent of OPCODE:
- T1 = 0x5E3 (EP, LM_N)
- T2 = 0xBE3 (CP)
- T3 = 0x263 (CE_N, LI_N)
REQ-007 LDA (0000) SHALL decode: T4 = 0x1A3 (EI_N, LM_N); T5 = 0x2C3 (CE_N, LA_N); T6 = 0x3E3.
REQ-008 ADD (0001) SHALL decode: T4 = 0x1A3; T5 = 0x2E1 (CE_N, LB_N); T6 = 0x3C7 (EU, LA_N).
REQ-009 SUB (0010) SHALL decode: T4 = 0x1A3; T5 = 0x2E1; T6 = 0x3CF (SU, EU, LA_N).
REQ-010 OUT (1110) SHALL decode: T4 = 0x3F2 (EA, LO_N); T5 = 0x3E3; T6 = 0x3E3.
REQ-011 All undefined opcodes (0011-1101) SHALL decode as NOP (0x3E3) in T4-T6 and SHALL NOT halt.
REQ-012 HLT (1111): when T = T4 and OPCODE = 1111, HLT SHALL assert combinationally in that cycle.
REQ-013 On the following rising edge, a registered halt flag SHALL set, and T SHALL freeze at T4.
REQ-014 While halted: HLT = 1, CON = 0x3E3 regardless of OPCODE, and T holds T4; only CLR SHALL exit the halted state.
REQ-015 In T1-T3, OPCODE SHALL be ignored; an OPCODE of 1111 in T1-T3 SHALL NOT assert HLT.
REQ-016 At most one of CP, EP, CE_N=0, EI_N=0, EA, EU (bus drivers) SHALL be active in any state; this is a required invariant.
REQ-017 If T is ever observed non-one-hot, the next rising edge SHALL force T = T1 (self-recovery).

Reset
REQ-018 While CLR = 1: T = 000001 (T1), halt flag = 0, HLT = 0, and CON = 0x5E3.
REQ-019 CLR asserted in any state, including mid-instruction or while halted, SHALL take effect immediately, without waiting for a clock edge.
REQ-020 The first rising edge after CLR deasserts SHALL advance T to T2.

Verification
REQ-021 Reset, then LDA: pulse CLR, run 6 edges with OPCODE = 0000 -> CON sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, 0x3E3, then T returns to T1.
REQ-022 ADD then SUB back-to-back -> T6 CON = 0x3C7 in the first instruction and 0x3CF in the second; T1 follows each T6 with no gap.
REQ-023 OUT, then an undefined opcode 0101 -> T4 CON = 0x3F2 for OUT; T4-T6 CON = 0x3E3 for 0101; HLT stays 0 throughout.
REQ-024 HLT -> HLT = 1 in T4; T remains 001000 for 10+ further edges with CON = 0x3E3; OPCODE changed to 0000 while halted has no effect.
REQ-025 CLR mid-T5 of ADD, asynchronously between edges -> T = T1 and CON = 0x5E3 before the next edge.
REQ-026 All runs -> T one-hot every cycle, and the bus-driver invariant of REQ-016 holds every cycle (checked by assertion).
